// File: rtl/adder_accumulate_ctrl_if.sv
// Bundle for the accumulator controller: operand stream, external adder link, result stream.
interface adder_accumulate_ctrl_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_sub;
  logic               in_last;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic               add_cin;
  logic [31:0]        add_sum;
  logic               add_ovf;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_sum;
  logic               out_ovf;
  logic [COUNT_W-1:0] out_count;

  // Controller side
  modport slave (
    input  in_valid, in_data, in_sub, in_last, add_sum, add_ovf, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, out_count
  );

  // Environment side: operand source, adder and result sink
  modport master (
    output in_valid, in_data, in_sub, in_last, add_sum, add_ovf, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/adder_accumulate_ctrl.sv
// Frame accumulator: adds/subtracts a stream of signed operands through an external
// 32-bit adder and returns the frame sum with sticky overflow and operand count.
module adder_accumulate_ctrl #(
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_accumulate_ctrl_if.slave bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]        POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0]        NEG_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [31:0]        acc, acc_d;
  logic               ovf, ovf_d;
  logic [COUNT_W-1:0] count, count_d;
  logic [31:0]        next_val;
  logic               accept;

  // Adder operands: first operand of a frame is added to zero; subtraction is a + ~b + 1
  assign bus.add_a   = (state == IDLE) ? 32'h0 : acc;
  assign bus.add_b   = bus.in_sub ? ~bus.in_data : bus.in_data;
  assign bus.add_cin = bus.in_sub;

  // Handshakes and result come straight from the state/datapath registers
  assign bus.in_ready  = !rst && (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.out_count = count;

  assign accept = bus.in_valid && bus.in_ready;

  // Clamp direction follows the effective addend sign: positive addend can only overflow upward
  always_comb begin
    next_val = bus.add_sum;
    if (SATURATE && bus.add_ovf) begin
      next_val = bus.add_b[31] ? NEG_MIN : POS_MAX;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    acc_d   = acc;
    ovf_d   = ovf;
    count_d = count;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_d   = next_val;
          ovf_d   = bus.add_ovf;
          count_d = COUNT_W'(1);
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = next_val;
          ovf_d   = ovf | bus.add_ovf;
          if (count != CNT_MAX) begin
            count_d = count + COUNT_W'(1);
          end
          if (bus.in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = 32'h0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Accumulator, sticky overflow and operand counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= 32'h0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      acc   <= acc_d;
      ovf   <= ovf_d;
      count <= count_d;
    end
  end

endmodule
